// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: widths, PC step and the fetch packet
// handed from fetch to decode.
package fetch_unit_pkg;

  localparam int XLEN     = 32;
  localparam int INST_W   = 32;
  localparam int FQ_DEPTH = 2;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] pc
  );
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO with flush; head is read straight from
// storage so downstream sees registered values only.
module fetch_queue
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fetch_pkt_t push_pkt,
  output fetch_pkt_t head_pkt,
  output logic [1:0] count
);

  fetch_pkt_t mem [FQ_DEPTH];

  logic head_ptr;
  logic tail_ptr;
  logic do_push;
  logic do_pop;

  assign do_pop  = pop && (count != 2'd0) && !flush;
  assign do_push = push && !flush &&
                   ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) tail_ptr <= ~tail_ptr;
      if (do_pop)  head_ptr <= ~head_ptr;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_ptr] <= push_pkt;
  end

  assign head_pkt = mem[head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads imem combinationally and
// queues {pc, inst} for decode; redirects flush and reload the PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] io_imem_addr,
  input  logic [31:0]       io_imem_data,
  input  logic              io_redirect_valid,
  input  logic [31:0]       io_redirect_pc,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [31:0]       io_out_inst,
  output logic [31:0]       io_out_pc
);

  logic [XLEN-1:0] pc;
  logic [1:0]      count;
  logic            pop;
  logic            push;
  fetch_pkt_t      push_pkt;
  fetch_pkt_t      head_pkt;

  assign io_out_valid = (count != 2'd0);
  assign pop          = io_out_valid && io_out_ready;
  assign push         = !io_redirect_valid &&
                        ((count != 2'd2) || pop);

  assign io_imem_addr = pc[ADDR_W+1:2];

  always_comb begin
    push_pkt      = '0;
    push_pkt.pc   = pc;
    push_pkt.inst = io_imem_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (io_redirect_valid) begin
      pc <= align_pc(io_redirect_pc);
    end else if (push) begin
      pc <= pc + PC_INC;
    end
  end

  fetch_queue u_queue (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .flush    (io_redirect_valid),
    .push_pkt (push_pkt),
    .head_pkt (head_pkt),
    .count    (count)
  );

  assign io_out_inst = head_pkt.inst;
  assign io_out_pc   = head_pkt.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a queue-level model,
// plus literal expectations for the directed scenarios.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [9:0]  io_imem_addr;
  logic [31:0] io_imem_data;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_inst;
  logic [31:0] io_out_pc;

  logic [31:0] imem [1024];
  assign io_imem_data = imem[io_imem_addr];

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (10)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .io_imem_addr      (io_imem_addr),
    .io_imem_data      (io_imem_data),
    .io_redirect_valid (io_redirect_valid),
    .io_redirect_pc    (io_redirect_pc),
    .io_out_valid      (io_out_valid),
    .io_out_ready      (io_out_ready),
    .io_out_inst       (io_out_inst),
    .io_out_pc         (io_out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model: queue of {pc, inst} entries plus the next fetch PC.
  logic [63:0] mq [$];
  logic [31:0] m_pc;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endfunction

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("valid", {31'd0, io_out_valid},
          {31'd0, mq.size() != 0});
      chk("imem_addr", {22'd0, io_imem_addr},
          {22'd0, m_pc[11:2]});
      if (mq.size() != 0) begin
        chk("out_pc", io_out_pc, mq[0][63:32]);
        chk("out_inst", io_out_inst, mq[0][31:0]);
      end
    end
  end

  task automatic drive(input logic r, input logic rv,
                       input logic [31:0] rpc);
    bit pop_m;
    bit push_m;
    io_out_ready      = r;
    io_redirect_valid = rv;
    io_redirect_pc    = rpc;
    pop_m  = (mq.size() != 0) && r;
    push_m = !rv && ((mq.size() < 2) || pop_m);
    if (rv) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back({m_pc, imem[m_pc[11:2]]});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic r, input logic rv,
                      input logic [31:0] rpc);
    drive(r, rv, rpc);
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = i;
    reset_n           = 1'b0;
    io_out_ready      = 1'b0;
    io_redirect_valid = 1'b0;
    io_redirect_pc    = 32'd0;
    m_pc              = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, io_out_valid}, 32'd0);
    chk("rst_addr", {22'd0, io_imem_addr}, 32'd0);

    // Streaming from reset with ready held high.
    reset_n = 1'b1;
    chk_en  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'd0);
      chk("stream_pc", io_out_pc, k * 4);
      chk("stream_inst", io_out_inst, k);
      chk("stream_addr", {22'd0, io_imem_addr}, k + 1);
    end

    // Fill to two entries, then async reset mid-cycle.
    step(1'b0, 1'b0, 32'd0);
    #2;
    reset_n = 1'b0;
    mq.delete();
    m_pc = 32'd0;
    #1;
    chk("arst_valid", {31'd0, io_out_valid}, 32'd0);
    chk("arst_addr", {22'd0, io_imem_addr}, 32'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;

    // Backpressure from reset.
    step(1'b0, 1'b0, 32'd0);
    chk("bp_first_pc", io_out_pc, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'd0);
      chk("bp_addr", {22'd0, io_imem_addr}, 32'd2);
      chk("bp_head", io_out_pc, 32'd0);
    end
    step(1'b1, 1'b0, 32'd0);
    chk("bp_drain1", io_out_pc, 32'd4);
    step(1'b1, 1'b0, 32'd0);
    chk("bp_drain2", io_out_pc, 32'd8);

    // Redirect while full.
    step(1'b1, 1'b1, 32'h103);
    chk("rd_valid", {31'd0, io_out_valid}, 32'd0);
    chk("rd_addr", {22'd0, io_imem_addr}, 32'h40);
    step(1'b1, 1'b0, 32'd0);
    chk("rd_pc", io_out_pc, 32'h100);
    chk("rd_inst", io_out_inst, 32'd64);

    // Redirect with a live handshake: head is dropped.
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h200);
    chk("rdh_valid", {31'd0, io_out_valid}, 32'd0);

    // PC and word-address wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wr_addr0", {22'd0, io_imem_addr}, 32'h3FF);
    step(1'b1, 1'b0, 32'd0);
    chk("wr_pc0", io_out_pc, 32'hFFFF_FFFC);
    chk("wr_inst0", io_out_inst, 32'd1023);
    chk("wr_addr1", {22'd0, io_imem_addr}, 32'h000);
    step(1'b1, 1'b0, 32'd0);
    chk("wr_pc1", io_out_pc, 32'h0000_0000);
    chk("wr_inst1", io_out_inst, 32'd0);

    // Random traffic over random memory contents.
    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0,
           $urandom);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage between the program counter and decode. Owns the PC, drives the word address of the 1024×32 combinational-read instruction memory, and captures the returned word with its PC into a 2-entry queue. Decode drains the queue through a valid/ready handshake. Branch and jump redirects flush the queue and reload the PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 10: instruction memory word-address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- io_imem_addr  out  ADDR_W  word address to instruction memory, = pc[ADDR_W+1:2].
- io_imem_data  in  32  instruction word at io_imem_addr, valid in the same cycle (combinational read).
- io_redirect_valid  in  1  load a new PC this cycle.
- io_redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0.
- io_out_valid  out  1  queue head holds a valid instruction.
- io_out_ready  in  1  decode accepts the head this cycle.
- io_out_inst  out  32  head instruction.
- io_out_pc  out  32  PC of the head instruction.

## Operation
- State:
  - pc[31:0]
  - queue of 2 entries {pc, inst}, with head pointer, tail pointer and count (0..2).
- pop = io_out_valid && io_out_ready.
- push = !io_redirect_valid && (count < 2 || pop).
- On push: write {pc, io_imem_data} at the tail, then pc <= pc + 4.
  - pc wraps modulo 2^32.
  - io_imem_addr wraps modulo 2^ADDR_W words with no special handling.
- On pop: advance head. Pop and push in the same cycle leave count unchanged.
- Full queue without a pop: no push, pc holds, io_imem_addr holds.
- Redirect priority:
  - The redirect overrides push and pop: count <= 0, pointers reset, pc <= {io_redirect_pc[31:2], 2'b00}.
  - A head presented during the redirect cycle is discarded even if io_out_ready=1. Decode must not act on a handshake in a cycle where io_redirect_valid=1.
- Outputs:
  - io_out_valid = (count != 0).
  - io_out_inst and io_out_pc come from the head entry; they are don't-care when io_out_valid=0.
  - Once io_out_valid is high, io_out_inst and io_out_pc are held stable until pop or redirect.
- No combinational path from io_out_ready or io_redirect_* to io_out_*. io_out_* depends on registers only.

## Timing
- Reset values (asynchronous on reset_n low):
  - pc = RESET_PC, count = 0.
  - io_out_valid = 0.
  - io_imem_addr = RESET_PC[ADDR_W+1:2].
  - Queue data is not reset.
- First instruction: io_out_valid rises 1 cycle after reset_n deasserts and is sampled.
- Fetch-to-output latency: 1 cycle.
- Throughput: 1 instruction/cycle while io_out_ready=1.
- Redirect bubble:
  - Redirect at edge E0: io_out_valid=0 in the cycle after E0.
  - The target instruction is at the queue head after E1.
- Backpressure: 2 entries absorb 2 cycles of io_out_ready=0. pc then stalls.
- Reset asserted mid-operation: immediate return to reset state. In-flight queue contents are lost.

## Structure
- Shared package holds:
  - XLEN=32
  - INST_W=32
  - the PC increment constant 4
  - the fetch packet typedef {pc[31:0], inst[31:0]} reused by decode.
- One natural sub-module: fetch_queue, a 2-entry synchronous FIFO with push, pop and flush, plus count output.
- The PC register and the push/redirect logic stay in fetch_unit.

## Test plan
- Reset release, RESET_PC=0, imem[i]=i, io_out_ready=1:
  - io_out_pc = 0, 4, 8, … on consecutive cycles.
  - io_out_inst = 0, 1, 2, …
  - io_imem_addr = 0, 1, 2, …
- io_out_ready=0 for 5 cycles after valid:
  - count saturates at 2.
  - io_imem_addr freezes at 2.
  - Head stays pc=0.
  - After ready returns, pcs 0, 4, 8 come out in order with no gap and no duplicate.
- io_redirect_valid=1 with io_redirect_pc=32'h103 while the queue is full:
  - Next cycle: io_out_valid=0, io_imem_addr=10'h040.
  - Following cycle: io_out_pc=32'h100, io_out_inst=imem[64].
- Redirect and io_out_ready=1 in the same cycle with the queue non-empty: the head is not counted as consumed, and the queue empties.
- Wrap: redirect to 32'hFFFF_FFFC, then consume 2:
  - io_out_pc = FFFF_FFFC, then 0000_0000.
  - io_imem_addr = 3FF, then 000.
- reset_n pulsed low asynchronously, mid-cycle, with count=2: io_out_valid drops immediately, and pc=RESET_PC before the next clock edge.
